// File: rtl/xor_equiv_checker.sv
// xor_equiv_checker
//
// Clocked stimulus-and-compare engine for exhaustive equivalence checking of
// an N_IN-input, 1-output combinational pair. Every input vector is driven in
// ascending order, held for SETTLE cycles, and then the two outputs are compared.
// Mismatches are counted, and the first failing vector is recorded.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   start            run request, honoured only in IDLE or DONE
//   stim             vector driven to both implementations
//   f_dut, f_ref     outputs of the structural / behavioural implementation
//   busy             high in SETTLE and COMPARE
//   done             high in DONE
//   pass             done with zero mismatches
//   cmp_valid        one-cycle pulse per compared vector
//   cmp_match        result of the latest compare (held between compares)
//   fail_cnt         number of mismatching vectors in this run
//   first_fail_vec   stim value of the first mismatch
//   first_fail_valid a mismatch has been recorded in this run
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for start after reset
// SETTLE  | holding stim while the pair settles, cnt counts down
// COMPARE | one cycle; outputs sampled on the edge leaving it
// DONE    | results held until start or rst

module xor_equiv_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            f_dut,
  input  logic            f_ref,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            cmp_valid,
  output logic            cmp_match,
  output logic [N_IN:0]   fail_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  // Counter only needs to hold SETTLE-1; keep at least one bit.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cmp_valid_q, cmp_valid_d;
  logic            cmp_match_q, cmp_match_d;
  logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvld_q, ffvld_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stim_q      <= '0;
      cnt_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_match_q <= 1'b0;
      fail_cnt_q  <= '0;
      ffv_q       <= '0;
      ffvld_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      cnt_q       <= cnt_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_match_q <= cmp_match_d;
      fail_cnt_q  <= fail_cnt_d;
      ffv_q       <= ffv_d;
      ffvld_q     <= ffvld_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    cnt_d       = cnt_q;
    cmp_valid_d = 1'b0;
    cmp_match_d = cmp_match_q;
    fail_cnt_d  = fail_cnt_q;
    ffv_d       = ffv_q;
    ffvld_d     = ffvld_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          fail_cnt_d = '0;
          ffv_d      = '0;
          ffvld_d    = 1'b0;
          stim_d     = '0;
          cnt_d      = RELOAD;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_COMPARE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_COMPARE: begin
        cmp_valid_d = 1'b1;
        cmp_match_d = (f_dut == f_ref);
        if (f_dut != f_ref) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (!ffvld_q) begin
            ffv_d   = stim_q;
            ffvld_d = 1'b1;
          end
        end
        // The last vector leaves stim at all ones so the final state stays visible.
        if (stim_q == '1) begin
          state_d = S_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = RELOAD;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stim             = stim_q;
  assign busy             = (state_q == S_SETTLE) || (state_q == S_COMPARE);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (fail_cnt_q == '0);
  assign cmp_valid        = cmp_valid_q;
  assign cmp_match        = cmp_match_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvld_q;

endmodule
